// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use bubbles, branch flushes, and a freeze while data memory is slow.
// Control outputs are combinational; the memory-wait FSM, sticky error and event counters are registered.
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             Branch_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             Stall_o,
  output logic             Flush_o,
  output logic             NoOp_o,
  output logic             Freeze_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              memwait;
  logic              loaduse;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign memwait  = mem_req_i & ~mem_ack_i;
  assign loaduse  = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                    ((IDEX_RDaddr_i == IFID_RS1addr_i) || (IDEX_RDaddr_i == IFID_RS2addr_i));
  // wait_cnt never exceeds MEM_TIMEOUT-1, so the increment cannot overflow WAIT_W
  assign wait_nxt = wait_cnt + WAIT_W'(1);

  always_comb begin
    PCWrite_o = 1'b1;
    Stall_o   = 1'b0;
    Flush_o   = 1'b0;
    NoOp_o    = 1'b0;
    Freeze_o  = 1'b0;
    if (rst_i) begin
      PCWrite_o = 1'b1;
    end else if (state == ERR || memwait) begin
      Freeze_o  = 1'b1;
      Stall_o   = 1'b1;
      PCWrite_o = 1'b0;
    end else if (loaduse) begin
      // a taken branch is dropped here and re-resolves once the bubble has passed
      Stall_o   = 1'b1;
      NoOp_o    = 1'b1;
      PCWrite_o = 1'b0;
    end else if (Branch_i) begin
      Flush_o   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_err_o   <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (Stall_o) stall_cnt_o <= sat_inc(stall_cnt_o);
      if (Flush_o) flush_cnt_o <= sat_inc(flush_cnt_o);
      case (state)
        RUN, MEM_WAIT: begin
          if (memwait) begin
            if (wait_nxt >= WAIT_W'(MEM_TIMEOUT)) begin
              state     <= ERR;
              mem_err_o <= 1'b1;
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= wait_nxt;
            end
          end else begin
            // ack, or the request withdrawn without ack, both release the freeze
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default and narrow counters / short timeout) driven in
// lockstep, compared every cycle against a rule-level model, plus literal directed expectations.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       memread;
  logic [4:0] rd, rs1, rs2;
  logic       branch, mem_req, mem_ack;

  logic        a_pcw, a_stall, a_flush, a_noop, a_freeze, a_err;
  logic [31:0] a_scnt, a_fcnt;
  logic        b_pcw, b_stall, b_flush, b_noop, b_freeze, b_err;
  logic [3:0]  b_scnt, b_fcnt;

  int checks = 0;
  int errors = 0;

  // model state, index 0 = default instance, 1 = narrow instance
  bit      m_err   [2];
  int      m_waits [2];
  longint  m_scnt  [2];
  longint  m_fcnt  [2];
  int      m_to    [2] = '{16, 3};
  longint  m_max   [2] = '{64'hFFFF_FFFF, 64'hF};

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(memread), .IDEX_RDaddr_i(rd),
    .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2), .Branch_i(branch),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .PCWrite_o(a_pcw), .Stall_o(a_stall), .Flush_o(a_flush), .NoOp_o(a_noop),
    .Freeze_o(a_freeze), .mem_err_o(a_err), .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt));

  hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(memread), .IDEX_RDaddr_i(rd),
    .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2), .Branch_i(branch),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .PCWrite_o(b_pcw), .Stall_o(b_stall), .Flush_o(b_flush), .NoOp_o(b_noop),
    .Freeze_o(b_freeze), .mem_err_o(b_err), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // expected {PCWrite, Stall, Flush, NoOp, Freeze} straight from the priority rules
  function automatic logic [4:0] exp_ctrl(input int k);
    bit mw, lu;
    mw = mem_req && !mem_ack;
    lu = memread && (rd != 0) && (rd == rs1 || rd == rs2);
    if (rst)              return 5'b10000;
    if (m_err[k] || mw)   return 5'b01001;
    if (lu)               return 5'b01010;
    if (branch)           return 5'b10100;
    return 5'b10000;
  endfunction

  task automatic check_all();
    logic [4:0] e;
    e = exp_ctrl(0);
    chk("a_ctrl", {27'd0, a_pcw, a_stall, a_flush, a_noop, a_freeze}, {27'd0, e});
    chk("a_err",  {31'd0, a_err}, {31'd0, m_err[0]});
    chk("a_scnt", a_scnt, m_scnt[0][31:0]);
    chk("a_fcnt", a_fcnt, m_fcnt[0][31:0]);
    e = exp_ctrl(1);
    chk("b_ctrl", {27'd0, b_pcw, b_stall, b_flush, b_noop, b_freeze}, {27'd0, e});
    chk("b_err",  {31'd0, b_err}, {31'd0, m_err[1]});
    chk("b_scnt", {28'd0, b_scnt}, m_scnt[1][31:0]);
    chk("b_fcnt", {28'd0, b_fcnt}, m_fcnt[1][31:0]);
  endtask

  task automatic model_clock();
    logic [4:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_ctrl(k);
      if (rst) begin
        m_err[k] = 0; m_waits[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
      end else begin
        if (e[3] && m_scnt[k] < m_max[k]) m_scnt[k]++;
        if (e[2] && m_fcnt[k] < m_max[k]) m_fcnt[k]++;
        if (!m_err[k]) begin
          if (mem_req && !mem_ack) begin
            m_waits[k]++;
            if (m_waits[k] >= m_to[k]) m_err[k] = 1;
          end else begin
            m_waits[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    rst = 0; memread = 0; rd = 0; rs1 = 0; rs2 = 0; branch = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0; m_waits[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    // reset state
    #1 chk("rst_pcw", {31'd0, a_pcw}, 32'd1);
    chk("rst_stall", {31'd0, a_stall}, 32'd0);
    step();
    rst = 0;

    // load-use on rs1
    memread = 1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0;
    #1 chk("lu_stall", {31'd0, a_stall}, 32'd1);
    chk("lu_noop", {31'd0, a_noop}, 32'd1);
    chk("lu_pcw", {31'd0, a_pcw}, 32'd0);
    step();
    chk("lu_scnt", a_scnt, 32'd1);

    // load to x0 is never a hazard
    rd = 5'd0; rs1 = 5'd0;
    #1 chk("x0_pcw", {31'd0, a_pcw}, 32'd1);
    chk("x0_stall", {31'd0, a_stall}, 32'd0);
    step();

    // taken branch flushes; load-use suppresses it
    idle(); branch = 1;
    #1 chk("br_flush", {31'd0, a_flush}, 32'd1);
    step();
    chk("br_fcnt", a_fcnt, 32'd1);
    memread = 1; rd = 5'd7; rs2 = 5'd7;
    #1 chk("brlu_flush", {31'd0, a_flush}, 32'd0);
    chk("brlu_stall", {31'd0, a_stall}, 32'd1);
    step();

    // memory ack after three wait cycles
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_freeze", {31'd0, a_freeze}, 32'd1);
      step();
    end
    mem_ack = 1;
    #1 chk("ack_freeze", {31'd0, a_freeze}, 32'd0);
    step();
    idle();
    chk("mw_scnt", a_scnt, 32'd3);
    step();

    // timeout: 16 waits set the sticky error, reset clears it
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 15; i++) step();
    chk("to_err15", {31'd0, a_err}, 32'd0);
    step();
    chk("to_err16", {31'd0, a_err}, 32'd1);
    mem_req = 0;
    #1 chk("err_freeze", {31'd0, a_freeze}, 32'd1);
    step();
    do_reset();
    chk("rst_err", {31'd0, a_err}, 32'd0);
    chk("rst_scnt", a_scnt, 32'd0);
    step();

    // counter saturation on the 4-bit instance
    do_reset();
    memread = 1; rd = 5'd3; rs1 = 5'd3;
    for (int i = 0; i < 20; i++) step();
    chk("sat_b", {28'd0, b_scnt}, 32'h0000_000F);
    chk("sat_a", a_scnt, 32'd20);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(99) == 0);
      memread = $urandom_range(1) == 1;
      rd      = 5'($urandom_range(3));
      rs1     = 5'($urandom_range(3));
      rs2     = 5'($urandom_range(3));
      branch  = $urandom_range(3) == 0;
      mem_req = $urandom_range(2) != 0;
      mem_ack = $urandom_range(3) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
